// File: rtl/fp11_pkg.sv
// Shared definitions for the 11-bit mini-float family: field layout, bias,
// saturation pattern, result bundle and the divider control states.
package fp11_pkg;
  localparam int FP_W     = 11;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 4;
  localparam int SIGN_POS = 10;
  localparam int EXP_HI   = 9;
  localparam int EXP_LO   = 4;
  localparam int QUO_W    = MAN_W + 2;

  localparam logic signed [7:0] EXP_BIAS = 8'sd31;
  localparam logic [EXP_W-1:0]  EXP_SAT  = 6'h3F;
  localparam logic [MAN_W-1:0]  MAN_SAT  = 4'hF;

  typedef struct packed {
    logic [FP_W-1:0] quo;
    logic            ovf;
    logic            unf;
  } fp11_res_t;

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_e;
endpackage

// File: rtl/fp11_mant_div.sv
// Iterative restoring mantissa divider: one quotient bit per cycle after start,
// MSB first, QUO_W cycles in total. 'last' marks the cycle producing the LSB.
module fp11_mant_div
  import fp11_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAN_W-1:0] a_man,
  input  logic [MAN_W-1:0] b_man,
  output logic             last,
  output logic [QUO_W-1:0] q
);
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W:0]   div_q, div_d, diff;
  logic [QUO_W-1:0] q_q, q_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             ge;

  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    run_d = run_q;
    ge    = rem_q >= {1'b0, div_q};
    // remainder after a successful subtract is below the divisor, so 5 bits hold it
    diff  = rem_q[MAN_W:0] - div_q;
    last  = run_q && (cnt_q == 3'(QUO_W - 1));
    if (start) begin
      rem_d = {2'b01, a_man};
      div_d = {1'b1, b_man};
      q_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = {(ge ? diff : rem_q[MAN_W:0]), 1'b0};
      q_d   = {q_q[QUO_W-2:0], ge};
      cnt_d = cnt_q + 3'd1;
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/fpdiv.sv
// 11-bit mini-float divider: accept, restoring mantissa divide, then one
// normalise/pack edge that registers quotient, flags and the done pulse.
module fpdiv
  import fp11_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] quotient,
  output logic            done,
  output logic            busy,
  output logic            dz,
  output logic            ovf,
  output logic            unf
);
  state_e            state_q, state_d;
  logic [FP_W-1:0]   quo_q, quo_d;
  logic              done_q, done_d, dz_q, dz_d, ovf_q, ovf_d, unf_q, unf_d;
  logic              sign_q, sign_d, sp_dz_q, sp_dz_d, sp_zero_q, sp_zero_d;
  logic signed [7:0] exp_q, exp_d;
  logic              special, div_start, div_last;
  logic [QUO_W-1:0]  div_q;
  fp11_res_t         res;

  function automatic fp11_res_t pack_result(input logic s, input logic signed [7:0] e,
                                            input logic [MAN_W-1:0] m);
    fp11_res_t r;
    r.quo = {s, e[EXP_W-1:0], m};
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (e > 8'sd63) begin
      r.quo = {s, EXP_SAT, MAN_SAT};
      r.ovf = 1'b1;
    end else if (e < 8'sd0) begin
      r.quo = {s, {(FP_W-1){1'b0}}};
      r.unf = 1'b1;
    end
    return r;
  endfunction

  fp11_mant_div u_mant_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a_man (a[MAN_W-1:0]),
    .b_man (b[MAN_W-1:0]),
    .last  (div_last),
    .q     (div_q)
  );

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    sp_dz_d   = sp_dz_q;
    sp_zero_d = sp_zero_q;
    res       = '0;
    special   = (b == '0) || (a == '0);
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          div_start = !special;
          sign_d    = a[SIGN_POS] ^ b[SIGN_POS];
          exp_d     = $signed({2'b00, a[EXP_HI:EXP_LO]}) - $signed({2'b00, b[EXP_HI:EXP_LO]})
                      + EXP_BIAS;
          sp_dz_d   = (b == '0);
          sp_zero_d = (b != '0) && (a == '0);
          state_d   = special ? NORM : CALC;
        end
      end
      CALC: if (div_last) state_d = NORM;
      NORM: begin
        // quotient MSB clear means ratio < 1: take one more bit, one less exponent
        if (div_q[QUO_W-1]) res = pack_result(sign_q, exp_q, div_q[QUO_W-2:1]);
        else                res = pack_result(sign_q, exp_q - 8'sd1, div_q[MAN_W-1:0]);
        if (sp_dz_q) begin
          res.quo = {sign_q, EXP_SAT, MAN_SAT};
          res.ovf = 1'b0;
          res.unf = 1'b0;
        end else if (sp_zero_q) begin
          res = '0;
          res.quo[SIGN_POS] = sign_q;
        end
        quo_d   = res.quo;
        ovf_d   = res.ovf;
        unf_d   = res.unf;
        dz_d    = sp_dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      sp_dz_q   <= 1'b0;
      sp_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      sp_dz_q   <= sp_dz_d;
      sp_zero_q <= sp_zero_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign dz       = dz_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
endmodule

// File: tb/tb_fpdiv.sv
// Bench for fpdiv: directed cases, random operands against a value-level
// model, busy-time in_ready, mid-divide reset and back-to-back operation.
module tb_fpdiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_ready = 1'b0;
  logic [10:0] a = '0, b = '0;
  logic [10:0] quotient;
  logic        done, busy, dz, ovf, unf;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  fpdiv dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .a(a), .b(b),
    .quotient(quotient), .done(done), .busy(busy), .dz(dz), .ovf(ovf), .unf(unf)
  );

  // returns {quotient, dz, ovf, unf}
  function automatic logic [13:0] model(input logic [10:0] x, input logic [10:0] y);
    logic s;
    int ea, eb, ma, mb, q, e, man;
    logic [5:0] e6;
    logic [3:0] m4;
    s = x[10] ^ y[10];
    if (y == 11'h000) return {s, 10'h3FF, 3'b100};
    if (x == 11'h000) return {s, 10'h000, 3'b000};
    ea = int'(x[9:4]); eb = int'(y[9:4]);
    ma = 16 + int'(x[3:0]); mb = 16 + int'(y[3:0]);
    q = (ma * 32) / mb;
    if (q >= 32) begin man = (q / 2) % 16; e = ea - eb + 31; end
    else begin man = q % 16; e = ea - eb + 30; end
    if (e > 63) return {s, 10'h3FF, 3'b010};
    if (e < 0)  return {s, 10'h000, 3'b001};
    e6 = 6'(e); m4 = 4'(man);
    return {s, e6, m4, 3'b000};
  endfunction

  function automatic int model_lat(input logic [10:0] x, input logic [10:0] y);
    return (x == 11'h000 || y == 11'h000) ? 1 : 7;
  endfunction

  task automatic start_op(input logic [10:0] x, input logic [10:0] y);
    a = x; b = y; in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 20);
  endtask

  task automatic test_reset();
    total++;
    if ({quotient, done, busy, dz, ovf, unf} !== 16'h0) begin
      $display("FAIL reset_state got %h expected 0000", {quotient, done, busy, dz, ovf, unf});
    end else passed++;
  endtask

  task automatic test_directed();
    logic [10:0] ta[7] = '{11'h218, 11'h1F0, 11'h5F0, 11'h1F0, 11'h000, 11'h3F0, 11'h010};
    logic [10:0] tb[7] = '{11'h200, 11'h208, 11'h1F0, 11'h000, 11'h200, 11'h010, 11'h3F0};
    logic [10:0] tq[7] = '{11'h208, 11'h1D5, 11'h5F0, 11'h3FF, 11'h000, 11'h3FF, 11'h000};
    logic [2:0]  tf[7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b001};
    int          tl[7] = '{7, 7, 7, 1, 1, 7, 7};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i]);
      total++;
      if (busy !== 1'b1) $display("FAIL dir%0d_busy got %b expected 1", i, busy);
      else passed++;
      wait_done(cyc);
      total++;
      if (cyc != tl[i]) $display("FAIL dir%0d_latency got %0d expected %0d", i, cyc, tl[i]);
      else passed++;
      total++;
      if (quotient !== tq[i]) $display("FAIL dir%0d_quotient got %h expected %h", i, quotient, tq[i]);
      else passed++;
      total++;
      if ({dz, ovf, unf} !== tf[i]) $display("FAIL dir%0d_flags got %b expected %b", i, {dz, ovf, unf}, tf[i]);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL dir%0d_busy_done got %b expected 0", i, busy);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) $display("FAIL dir%0d_done_pulse got %b expected 0", i, done);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [10:0] x, y;
    logic [13:0] exp_v;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      x = 11'($urandom);
      y = 11'($urandom);
      if ($urandom_range(9) == 0) x = 11'h000;
      if ($urandom_range(9) == 0) y = 11'h000;
      exp_v = model(x, y);
      start_op(x, y);
      wait_done(cyc);
      total++;
      if (cyc != model_lat(x, y)) $display("FAIL rnd%0d_latency a=%h b=%h got %0d expected %0d", i, x, y, cyc, model_lat(x, y));
      else passed++;
      total++;
      if ({quotient, dz, ovf, unf} !== exp_v)
        $display("FAIL rnd%0d_result a=%h b=%h got %h expected %h", i, x, y, {quotient, dz, ovf, unf}, exp_v);
      else passed++;
      total++;
      if ($countones({dz, ovf, unf}) > 1) $display("FAIL rnd%0d_flags_exclusive got %b expected at most one set", i, {dz, ovf, unf});
      else passed++;
    end
  endtask

  task automatic test_ignore_busy();
    int cyc, extra;
    start_op(11'h218, 11'h200);
    repeat (2) @(posedge clk);
    #1;
    a = 11'h1F0; b = 11'h208; in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    wait_done(cyc);
    total++;
    if (cyc != 4) $display("FAIL ignore_latency got %0d expected 4", cyc);
    else passed++;
    total++;
    if (quotient !== 11'h208) $display("FAIL ignore_quotient got %h expected 208", quotient);
    else passed++;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL ignore_no_second_done got %0d expected 0", extra);
    else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int cyc, seen;
    start_op(11'h3F0, 11'h010);
    wait_done(cyc);
    start_op(11'h218, 11'h200);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({quotient, done, busy, dz, ovf, unf} !== 16'h0)
      $display("FAIL midreset_outputs got %h expected 0000", {quotient, done, busy, dz, ovf, unf});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midreset_no_done got %0d expected 0", seen);
    else passed++;
    start_op(11'h1F0, 11'h208);
    wait_done(cyc);
    total++;
    if (cyc != 7 || quotient !== 11'h1D5)
      $display("FAIL midreset_next_op got lat=%0d q=%h expected lat=7 q=1d5", cyc, quotient);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] xs[6], ys[6];
    int cyc;
    for (int i = 0; i < 6; i++) begin
      xs[i] = 11'($urandom);
      ys[i] = (i == 2) ? 11'h000 : 11'($urandom);
    end
    start_op(xs[0], ys[0]);
    for (int i = 0; i < 6; i++) begin
      wait_done(cyc);
      total++;
      if (cyc != model_lat(xs[i], ys[i]) || {quotient, dz, ovf, unf} !== model(xs[i], ys[i]))
        $display("FAIL b2b%0d got lat=%0d res=%h expected lat=%0d res=%h", i, cyc,
                 {quotient, dz, ovf, unf}, model_lat(xs[i], ys[i]), model(xs[i], ys[i]));
      else passed++;
      if (i < 5) start_op(xs[i+1], ys[i+1]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_mid_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
